// File: rtl/lpf_fir_mc.sv
// Multi-channel low-pass FIR: one delay line per channel and a single shared
// multiply-accumulate unit that processes one tap per clock.
module lpf_fir_mc #(
    parameter int N    = 16,
    parameter int TAPS = 13,
    parameter int CH   = 2,
    parameter int CW   = 16,
    parameter int FRAC = 15,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW  = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic signed [N-1:0]  data_in,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_err,
    output logic                 out_valid,
    output logic [CHW-1:0]       out_ch,
    output logic signed [N-1:0]  data_out,
    output logic                 busy
);

    localparam int ACCW = N + CW + $clog2(TAPS);
    localparam int PW   = N + CW;

    localparam logic signed [CW-1:0]   COEF0 = CW'((1 << FRAC) - 1);
    localparam logic signed [ACCW-1:0] HALF  = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] YMAX  = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN  = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state_q, state_d;
    logic signed [N-1:0]    xline_q [CH][TAPS];
    logic signed [CW-1:0]   coef_q  [TAPS];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          k_q, k_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic signed [N-1:0]    data_out_q, data_out_d;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic                   out_valid_q, out_valid_d;
    logic                   coef_err_q, coef_err_d;

    logic                   take;
    logic                   coef_ok;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] rnd;
    logic signed [ACCW-1:0] shifted;
    logic signed [N-1:0]    y;

    // Samples tagged with a channel that does not exist are simply never taken.
    assign take    = (state_q == IDLE) && in_valid && (int'(in_ch) < CH);
    assign coef_ok = (state_q == IDLE) && (int'(coef_addr) < TAPS);

    always_comb begin
        prod    = xline_q[ch_q][k_q] * coef_q[k_q];
        rnd     = acc_q + HALF;
        shifted = rnd >>> FRAC;
        if (shifted > YMAX) begin
            y = YMAX[N-1:0];
        end else if (shifted < YMIN) begin
            y = YMIN[N-1:0];
        end else begin
            y = shifted[N-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        k_d         = k_q;
        ch_d        = ch_q;
        data_out_d  = data_out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        coef_err_d  = coef_we && !coef_ok;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = MAC;
                    ch_d    = in_ch;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                k_d   = k_q + 1'b1;
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                data_out_d  = y;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Coefficients also return to their near pass-through default on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            ch_q        <= '0;
            data_out_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            coef_err_q  <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    xline_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= (k == 0) ? COEF0 : '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            ch_q        <= ch_d;
            data_out_q  <= data_out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            coef_err_q  <= coef_err_d;
            if (take) begin
                xline_q[in_ch][0] <= data_in;
                for (int k = 1; k < TAPS; k++) begin
                    xline_q[in_ch][k] <= xline_q[in_ch][k-1];
                end
            end
            if (coef_we && coef_ok) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign data_out  = data_out_q;
    assign coef_err  = coef_err_q;

endmodule
